// File: rtl/oc_bank_arbiter.sv
// Read-port arbiter for the 4-bank operand register file: per-bank round-robin grant,
// writeback blocking, and a two-stage pipeline that tags bank read data with the winner id.
module oc_bank_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int NUM_BANK = 4,
  parameter int REG_ID_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*REG_ID_W-1:0]  req_reg_id,
  output logic [NUM_REQ-1:0]           req_gnt,
  input  logic                         wb_vld,
  input  logic [REG_ID_W-1:0]          wb_reg_id,
  output logic [NUM_BANK-1:0]          bk_rd_en,
  output logic [NUM_BANK*3-1:0]        bk_rd_addr,
  output logic [NUM_BANK*3-1:0]        bk_ocid,
  output logic [NUM_BANK-1:0]          bk_vld,
  output logic [NUM_BANK-1:0]          bk_bz
);

  localparam int ID_W   = 3;
  localparam int ROW_W  = 3;
  localparam int BANK_W = 2;

  logic [ID_W-1:0]   ptr     [NUM_BANK];
  logic [BANK_W-1:0] tgt     [NUM_REQ];
  logic [ROW_W-1:0]  row     [NUM_REQ];
  logic [ID_W-1:0]   win_id  [NUM_BANK];
  logic [NUM_BANK-1:0] win_vld;
  logic [NUM_BANK-1:0] wb_blk;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   s1_id   [NUM_BANK];
  logic [NUM_BANK-1:0] s1_bz;
  logic              wb_row_unused;

  // The writeback row does not matter here; only its bank is blocked.
  assign wb_row_unused = ^wb_reg_id[ROW_W-1:0];

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      tgt[r] = req_reg_id[r*REG_ID_W+ROW_W +: BANK_W];
      row[r] = req_reg_id[r*REG_ID_W +: ROW_W];
    end
  end

  // Per bank: first candidate at or after ptr, searching upward with natural 3-bit wrap.
  always_comb begin
    req_gnt = '0;
    win_vld = '0;
    wb_blk  = '0;
    idx     = '0;
    for (int b = 0; b < NUM_BANK; b++) win_id[b] = '0;
    if (wb_vld) wb_blk[wb_reg_id[ROW_W +: BANK_W]] = 1'b1;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (!rst && !wb_blk[b]) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = ptr[b] + ID_W'(i);
          if (!win_vld[b] && req_vld[idx] && tgt[idx] == BANK_W'(b)) begin
            win_vld[b] = 1'b1;
            win_id[b]  = idx;
          end
        end
      end
      if (win_vld[b]) req_gnt[win_id[b]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        ptr[b]   <= '0;
        s1_id[b] <= '0;
      end
      s1_bz      <= '0;
      bk_rd_en   <= '0;
      bk_rd_addr <= '0;
      bk_ocid    <= '0;
      bk_vld     <= '0;
      bk_bz      <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        bk_rd_en[b] <= win_vld[b];
        s1_bz[b]    <= wb_blk[b];
        if (win_vld[b]) begin
          ptr[b]                  <= win_id[b] + 3'd1;
          s1_id[b]                <= win_id[b];
          bk_rd_addr[b*3 +: 3]    <= row[win_id[b]];
        end
        // Stage 2 lines the id up with the SRAM data; ocid holds when no read was issued.
        bk_vld[b] <= bk_rd_en[b];
        bk_bz[b]  <= s1_bz[b];
        if (bk_rd_en[b]) bk_ocid[b*3 +: 3] <= s1_id[b];
      end
    end
  end

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Bench for oc_bank_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a per-cycle grant history model.
module tb_oc_bank_arbiter;

  localparam int MAXC = 4096;

  logic        clk;
  logic        rst;
  logic [7:0]  req_vld;
  logic [39:0] req_reg_id;
  logic [7:0]  req_gnt;
  logic        wb_vld;
  logic [4:0]  wb_reg_id;
  logic [3:0]  bk_rd_en;
  logic [11:0] bk_rd_addr;
  logic [11:0] bk_ocid;
  logic [3:0]  bk_vld;
  logic [3:0]  bk_bz;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rst = -1;
  int m_ptr [4];
  int g_id  [MAXC][4];
  int g_row [MAXC][4];
  bit g_wb  [MAXC][4];
  logic [7:0]  m_last_gnt;
  logic [7:0]  e_gnt;
  logic [3:0]  e_en, e_vld, e_bz;
  logic [11:0] e_addr, e_ocid;
  logic [39:0] ids;

  oc_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_reg_id(req_reg_id), .req_gnt(req_gnt),
    .wb_vld(wb_vld), .wb_reg_id(wb_reg_id),
    .bk_rd_en(bk_rd_en), .bk_rd_addr(bk_rd_addr), .bk_ocid(bk_ocid),
    .bk_vld(bk_vld), .bk_bz(bk_bz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic [39:0] id,
                               input logic wv, input logic [4:0] wid, input logic r);
    req_vld    = v;
    req_reg_id = id;
    wb_vld     = wv;
    wb_reg_id  = wid;
    rst        = r;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: each cycle records the winner per bank; outputs are looked up from that history,
  // with any reset cycle discarding everything granted before it.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      e_gnt = '0;
      for (int b = 0; b < 4; b++) begin
        g_id[cyc][b]  = -1;
        g_row[cyc][b] = 0;
        g_wb[cyc][b]  = wb_vld && (int'(wb_reg_id[4:3]) == b);
        if (!rst && !g_wb[cyc][b]) begin
          for (int i = 0; i < 8; i++) begin
            int r;
            r = (m_ptr[b] + i) % 8;
            if (g_id[cyc][b] < 0 && req_vld[r] && int'(req_reg_id[5*r+3 +: 2]) == b) begin
              g_id[cyc][b]  = r;
              g_row[cyc][b] = int'(req_reg_id[5*r +: 3]);
            end
          end
        end
        if (g_id[cyc][b] >= 0) e_gnt[g_id[cyc][b]] = 1'b1;
      end
      checkOutput("gnt", {32'd0, req_gnt}, {32'd0, e_gnt});
      if (last_rst >= 0) begin
        e_en = '0; e_vld = '0; e_bz = '0; e_addr = '0; e_ocid = '0;
        for (int b = 0; b < 4; b++) begin
          e_en[b]  = (cyc - 1 > last_rst) && g_id[cyc-1][b] >= 0;
          e_vld[b] = (cyc - 2 > last_rst) && g_id[cyc-2][b] >= 0;
          e_bz[b]  = (cyc - 2 > last_rst) && g_wb[cyc-2][b];
          for (int c = cyc - 1; c > last_rst; c--)
            if (g_id[c][b] >= 0) begin
              e_addr[3*b +: 3] = 3'(g_row[c][b]);
              break;
            end
          for (int c = cyc - 2; c > last_rst; c--)
            if (g_id[c][b] >= 0) begin
              e_ocid[3*b +: 3] = 3'(g_id[c][b]);
              break;
            end
        end
        checkOutput("rd_en", {36'd0, bk_rd_en}, {36'd0, e_en});
        checkOutput("rd_addr", {28'd0, bk_rd_addr}, {28'd0, e_addr});
        checkOutput("vld", {36'd0, bk_vld}, {36'd0, e_vld});
        checkOutput("bz", {36'd0, bk_bz}, {36'd0, e_bz});
        checkOutput("ocid", {28'd0, bk_ocid}, {28'd0, e_ocid});
      end
      m_last_gnt = e_gnt;
      if (rst) begin
        for (int b = 0; b < 4; b++) m_ptr[b] = 0;
        last_rst = cyc;
      end else begin
        for (int b = 0; b < 4; b++)
          if (g_id[cyc][b] >= 0) m_ptr[b] = (g_id[cyc][b] + 1) % 8;
      end
      cyc++;
    end
  end

  initial begin
    for (int b = 0; b < 4; b++) m_ptr[b] = 0;
    m_last_gnt = '0;
    ids = '0;
    applyStimulus(8'h00, 40'd0, 1'b0, 5'd0, 1'b1);
    step;
    step;
    applyStimulus(8'h00, 40'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput("reset_rd_en", {36'd0, bk_rd_en}, 40'd0);
    checkOutput("reset_vld", {36'd0, bk_vld}, 40'd0);
    checkOutput("reset_ocid", {28'd0, bk_ocid}, 40'd0);
    step;

    // Two banks granted in the same cycle.
    ids = '0; ids[0 +: 5] = 5'd9; ids[25 +: 5] = 5'd2;
    applyStimulus(8'b0010_0001, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t1_gnt", {32'd0, req_gnt}, 40'h21);
    step; applyStimulus(8'h00, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput("t1_rd_en", {36'd0, bk_rd_en}, 40'h3);
    checkOutput("t1_addr", {34'd0, bk_rd_addr[5:0]}, 40'b001_010);
    step;
    @(negedge clk);
    checkOutput("t1_vld", {36'd0, bk_vld}, 40'h3);
    checkOutput("t1_ocid", {34'd0, bk_ocid[5:0]}, 40'b000_101);
    step;

    // Three requesters on bank 2 served in id order.
    ids = '0; ids[5 +: 5] = 5'd16; ids[15 +: 5] = 5'd17; ids[30 +: 5] = 5'd18;
    applyStimulus(8'b0100_1010, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t2_gnt_a", {32'd0, req_gnt}, 40'h02);
    step; applyStimulus(8'b0100_1000, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t2_gnt_b", {32'd0, req_gnt}, 40'h08);
    step; applyStimulus(8'b0100_0000, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput("t2_gnt_c", {32'd0, req_gnt}, 40'h40);
    checkOutput("t2_ocid_a", {37'd0, bk_ocid[8:6]}, 40'd1);
    step; applyStimulus(8'h00, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t2_ocid_b", {37'd0, bk_ocid[8:6]}, 40'd3);
    step;
    @(negedge clk); checkOutput("t2_ocid_c", {37'd0, bk_ocid[8:6]}, 40'd6);
    step;

    // Bank 3 pointer wrap 7 -> 0 -> 1.
    ids = '0; ids[30 +: 5] = 5'd24;
    applyStimulus(8'b0100_0000, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t3_gnt_6", {32'd0, req_gnt}, 40'h40);
    step; ids = '0; ids[35 +: 5] = 5'd25; ids[0 +: 5] = 5'd26;
    applyStimulus(8'b1000_0001, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t3_gnt_7", {32'd0, req_gnt}, 40'h80);
    step; applyStimulus(8'b0000_0001, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t3_gnt_0", {32'd0, req_gnt}, 40'h01);
    step; ids = '0; ids[0 +: 5] = 5'd27; ids[10 +: 5] = 5'd28;
    applyStimulus(8'b0000_0101, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t3_gnt_2", {32'd0, req_gnt}, 40'h04);
    step; applyStimulus(8'b0000_0001, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t3_gnt_0b", {32'd0, req_gnt}, 40'h01);
    step;

    // Writeback blocks bank 2 for one cycle.
    ids = '0; ids[20 +: 5] = 5'd18;
    applyStimulus(8'b0001_0000, ids, 1'b1, 5'd17, 1'b0);
    @(negedge clk); checkOutput("t4_gnt_blk", {32'd0, req_gnt}, 40'h00);
    step; applyStimulus(8'b0001_0000, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t4_gnt", {32'd0, req_gnt}, 40'h10);
    step; applyStimulus(8'h00, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checkOutput("t4_bz", {39'd0, bk_bz[2]}, 40'd1);
    checkOutput("t4_vld_blk", {39'd0, bk_vld[2]}, 40'd0);
    step;
    @(negedge clk);
    checkOutput("t4_ocid", {37'd0, bk_ocid[8:6]}, 40'd4);
    checkOutput("t4_vld", {39'd0, bk_vld[2]}, 40'd1);
    step;

    // Reset right after a grant discards it.
    ids = '0; ids[10 +: 5] = 5'd0; ids[15 +: 5] = 5'd1;
    applyStimulus(8'b0000_0100, ids, 1'b0, 5'd0, 1'b0);
    @(negedge clk); checkOutput("t5_gnt", {32'd0, req_gnt}, 40'h04);
    step; applyStimulus(8'b0000_1000, ids, 1'b0, 5'd0, 1'b1);
    @(negedge clk); checkOutput("t5_gnt_rst", {32'd0, req_gnt}, 40'h00);
    step;
    @(negedge clk);
    checkOutput("t5_vld", {36'd0, bk_vld}, 40'h0);
    checkOutput("t5_gnt_rst2", {32'd0, req_gnt}, 40'h00);
    step; applyStimulus(8'h00, ids, 1'b0, 5'd0, 1'b0);
    step;

    // All eight on bank 0, held: strict rotation from pointer 0.
    ids = '0;
    for (int r = 0; r < 8; r++) ids[5*r +: 5] = 5'(r);
    applyStimulus(8'hFF, ids, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] want;
      want = 8'h01 << (i % 8);
      @(negedge clk); checkOutput("t6_gnt", {32'd0, req_gnt}, {32'd0, want});
      step;
    end
    applyStimulus(8'h00, ids, 1'b0, 5'd0, 1'b0);
    step;

    // Random traffic honouring the hold-until-granted rule.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] v;
      v = req_vld;
      for (int r = 0; r < 8; r++) begin
        if (!v[r] || m_last_gnt[r]) begin
          if ($urandom_range(0, 9) < 6) begin
            v[r] = 1'b1;
            ids[5*r +: 5] = 5'($urandom_range(0, 31));
          end else begin
            v[r] = 1'b0;
          end
        end
      end
      applyStimulus(v, ids, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 199) == 0));
      step;
    end
    applyStimulus(8'h00, ids, 1'b0, 5'd0, 1'b0);
    repeat (4) step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
